// File: rtl/cgra_ctrl_pkg.sv
// cgra_ctrl_pkg: shared state encoding and config word width for the PE config sequencer
package cgra_ctrl_pkg;
  localparam int CFG_WORD_W = 64;
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, RUN} seq_state_t;
endpackage

// File: rtl/config_regfile.sv
// config_regfile: NUM_PE x 64-bit config slots written one word at a time by index
module config_regfile
  import cgra_ctrl_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int IW = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [IW-1:0]                  idx,
  input  logic [CFG_WORD_W-1:0]          word,
  output logic [NUM_PE*CFG_WORD_W-1:0]   config_bits
);
  always_ff @(posedge clk)
    if (rst) config_bits <= '0;
    else
      for (int k = 0; k < NUM_PE; k++)
        if (we && idx == IW'(k)) config_bits[k*CFG_WORD_W +: CFG_WORD_W] <= word;
endmodule

// File: rtl/pe_config_sequencer.sv
// pe_config_sequencer: loads NUM_PE config words, pulses PE clear, then enables the array until stop/abort
module pe_config_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CFG_WORD_W-1:0]        cfg_word,
  input  logic                         cfg_word_v,
  output logic                         cfg_word_r,
  output logic [NUM_PE*CFG_WORD_W-1:0] config_bits,
  output logic                         pe_clr,
  output logic                         run,
  input  logic                         stop,
  output logic                         busy,
  output logic                         loaded
);
  localparam int IW = $clog2(NUM_PE + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_PE - 1);
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
  seq_state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [3:0] clr_cnt, clr_cnt_d;
  logic loaded_d, abort_hit, xfer;
  assign cfg_word_r = state == LOAD;
  assign abort_hit = abort && state != IDLE;
  assign xfer = cfg_word_r && cfg_word_v && !abort;
  always_comb begin
    state_d = state;
    idx_d = idx;
    clr_cnt_d = clr_cnt;
    loaded_d = abort_hit ? 1'b0 : loaded;
    if (abort) state_d = IDLE;
    else
      case (state)
        IDLE: if (start) begin
          state_d = LOAD;
          idx_d = '0;
          loaded_d = 1'b0;
        end
        LOAD: if (cfg_word_v) begin
          idx_d = idx + IW'(1);
          if (idx == LAST) begin
            state_d = CLEAR;
            loaded_d = 1'b1;
            clr_cnt_d = '0;
          end
        end
        CLEAR: begin
          state_d = clr_cnt == CLR_LAST ? RUN : CLEAR;
          clr_cnt_d = clr_cnt + 4'd1;
        end
        RUN: state_d = stop ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      clr_cnt <= '0;
      loaded <= 1'b0;
      pe_clr <= 1'b0;
      run <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      clr_cnt <= clr_cnt_d;
      loaded <= loaded_d;
      pe_clr <= state_d == CLEAR || abort_hit;
      run <= state_d == RUN;
      busy <= state_d != IDLE;
    end
  config_regfile #(.NUM_PE(NUM_PE), .IW(IW)) u_regfile (
    .clk(clk),
    .rst(rst),
    .we(xfer),
    .idx(idx),
    .word(cfg_word),
    .config_bits(config_bits)
  );
endmodule

// File: tb/tb_pe_config_sequencer.sv
// tb_pe_config_sequencer: scoreboard bench with a phase-level reference model and random plus directed stimulus
module tb_pe_config_sequencer;
  localparam int N = 4;
  localparam int C = 2;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, cfg_word_v = 1'b0, stop = 1'b0;
  logic [63:0] cfg_word = '0;
  logic cfg_word_r, pe_clr, run, busy, loaded;
  logic [N*64-1:0] config_bits;
  typedef struct packed {
    logic pe_clr;
    logic run;
    logic busy;
    logic loaded;
    logic rdy;
    logic [N*64-1:0] cfg;
  } snap_t;
  typedef enum int {P_IDLE, P_LOAD, P_CLEAR, P_RUN} phase_t;
  snap_t exp_q[$];
  int passed = 0, total = 0;
  phase_t ph = P_IDLE;
  int widx = 0, clr_left = 0;
  bit ld = 1'b0;
  logic [63:0] mem [N];
  always #5 clk = ~clk;
  pe_config_sequencer #(.NUM_PE(N), .CLR_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_word_v(cfg_word_v), .cfg_word_r(cfg_word_r),
    .config_bits(config_bits), .pe_clr(pe_clr), .run(run), .stop(stop),
    .busy(busy), .loaded(loaded)
  );
  task automatic chk(string n, logic [N*64-1:0] a, logic [N*64-1:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
  endtask
  task automatic step(bit r, bit s, bit a, bit v, logic [63:0] w, bit sp);
    snap_t e;
    bit pulse = 1'b0;
    if (r) begin
      ph = P_IDLE; widx = 0; ld = 1'b0;
      foreach (mem[k]) mem[k] = '0;
    end else if (a) begin
      if (ph != P_IDLE) begin ld = 1'b0; pulse = 1'b1; end
      ph = P_IDLE;
    end else
      case (ph)
        P_IDLE: if (s) begin ph = P_LOAD; widx = 0; ld = 1'b0; end
        P_LOAD: if (v) begin
          mem[widx] = w;
          widx++;
          if (widx == N) begin ph = P_CLEAR; ld = 1'b1; clr_left = C; end
        end
        P_CLEAR: begin
          clr_left--;
          if (clr_left == 0) ph = P_RUN;
        end
        P_RUN: if (sp) ph = P_IDLE;
      endcase
    e.pe_clr = pulse || ph == P_CLEAR;
    e.run = ph == P_RUN;
    e.busy = ph != P_IDLE;
    e.loaded = ld;
    e.rdy = ph == P_LOAD;
    e.cfg = '0;
    for (int k = 0; k < N; k++) e.cfg[k*64 +: 64] = mem[k];
    exp_q.push_back(e);
  endtask
  task automatic cyc(bit r, bit s, bit a, bit v, logic [63:0] w, bit sp);
    rst = r; start = s; abort = a; cfg_word_v = v; cfg_word = w; stop = sp;
    @(posedge clk);
    step(r, s, a, v, w, sp);
    #1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 64'h0, 0);
  endtask
  task automatic load_all(logic [63:0] base);
    cyc(0, 1, 0, 0, 64'h0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, base + 64'(i), 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      snap_t e;
      e = exp_q.pop_front();
      chk("pe_clr", N*64'(pe_clr), N*64'(e.pe_clr));
      chk("run", N*64'(run), N*64'(e.run));
      chk("busy", N*64'(busy), N*64'(e.busy));
      chk("loaded", N*64'(loaded), N*64'(e.loaded));
      chk("cfg_word_r", N*64'(cfg_word_r), N*64'(e.rdy));
      chk("config_bits", config_bits, e.cfg);
    end
  end
  initial begin
    mem = '{default: '0};
    cyc(1, 0, 0, 0, 64'h0, 0);
    cyc(1, 1, 0, 1, 64'hDEAD, 1);
    idle(1);
    load_all(64'hA0);
    idle(C + 4);
    cyc(0, 1, 0, 0, 64'h0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 64'h0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 64'h0, 1);
    idle(2);
    cyc(0, 1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, (i % 2) == 0, 64'hB0 + 64'(i), 0);
    idle(C + 2);
    cyc(0, 0, 0, 0, 64'h0, 1);
    cyc(0, 1, 0, 0, 64'h0, 0);
    cyc(0, 0, 0, 1, 64'hC0, 0);
    cyc(0, 0, 0, 1, 64'hC1, 0);
    cyc(0, 0, 1, 1, 64'hC2, 0);
    idle(2);
    cyc(0, 1, 1, 0, 64'h0, 0);
    idle(1);
    load_all(64'hD0);
    cyc(1, 0, 0, 0, 64'h0, 0);
    idle(1);
    load_all(64'hE0);
    idle(C + 2);
    cyc(0, 0, 1, 0, 64'h0, 0);
    idle(1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 4,
          $urandom_range(99) < 60, {$urandom, $urandom}, $urandom_range(99) < 10);
    idle(2);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
